vga_timing_gen: RTL and testbench

Parametrised raster timing generator for VGA-class displays. Runs on the already-generated pixel clock `sys_clk`. Produces aligned, registered h/v sync, display enable, pixel coordinates, blanking and line/frame strobes. Supersedes the fixed 640x480 sync block with:
- per-axis configurable porch, sync and active widths;
- configurable sync polarity;
- a pixel-clock enable for sub-rate pixel clocks;
- exact wrap at `TOTAL-1`.

---
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 tb/tb_vga_timing_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v position counters with a single
// registered decode stage so that syncs, enables, coordinates and strobes all
// describe the same pixel. pix_en gates both the counters and the output load,
// allowing sub-rate pixel clocks without a separate clock domain.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CW         = 11
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          display_en,
    output logic          vblank,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All decode thresholds are pre-sized to CW bits so every compare stays
    // at counter width. The sync end bound fits because the back porch is
    // non-empty, keeping it at or below TOTAL-1.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          H_ON       = (H_SYNC_POL != 0);
    localparam logic          V_ON       = (V_SYNC_POL != 0);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [CW-1:0] h_count_q, h_count_d;
    logic [CW-1:0] v_count_q, v_count_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          display_en_q, display_en_d;
    logic          vblank_q, vblank_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Counter advance and output decode from the pre-increment position.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        h_count_d     = h_count_q;
        v_count_d     = v_count_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        display_en_d  = display_en_q;
        vblank_d      = vblank_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end

            h_count_d     = h_cnt_q;
            v_count_d     = v_cnt_q;
            display_en_d  = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
            vblank_d      = (v_cnt_q >= V_VIS);
            h_sync_d      = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? H_ON : ~H_ON;
            v_sync_d      = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? V_ON : ~V_ON;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    // State and output registers; reset parks everything at pixel (0,0) idle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_count_q     <= '0;
            v_count_q     <= '0;
            h_sync_q      <= ~H_ON;
            v_sync_q      <= ~V_ON;
            display_en_q  <= 1'b0;
            vblank_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            display_en_q  <= display_en_d;
            vblank_q      <= vblank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign display_en  = display_en_q;
    assign vblank      = vblank_q;
    assign h_count     = h_count_q;
    assign v_count     = v_count_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-raster instance and a default 640x480
// instance, each mirrored by an index-based raster model (pixel number ->
// coordinates -> decoded levels), plus hand-computed literal expectations.
module tb_vga_timing_gen;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic reset_s, pe_s, reset_d, pe_d;

    logic       hs_s, vs_s, de_s, vb_s, ls_s, fs_s;
    logic [3:0] hc_s, vc_s;
    logic        hs_d, vs_d, de_d, vb_d, ls_d, fs_d;
    logic [10:0] hc_d, vc_d;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .CW(4)
    ) dut_s (
        .sys_clk(sys_clk), .reset(reset_s), .pix_en(pe_s),
        .h_sync(hs_s), .v_sync(vs_s), .display_en(de_s), .vblank(vb_s),
        .h_count(hc_s), .v_count(vc_s), .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_gen dut_d (
        .sys_clk(sys_clk), .reset(reset_d), .pix_en(pe_d),
        .h_sync(hs_d), .v_sync(vs_d), .display_en(de_d), .vblank(vb_d),
        .h_count(hc_d), .v_count(vc_d), .line_start(ls_d), .frame_start(fs_d)
    );

    typedef struct packed {
        logic        hs, vs, de, vb;
        logic [15:0] h, v;
        logic        ls, fs;
    } exp_t;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    endtask

    // Pixel number k within the frame maps to (k mod H_TOTAL, k div H_TOTAL).
    function automatic exp_t model(input int k, input int ha, input int hf, input int hsw,
                                   input int hb, input int va, input int vf, input int vsw,
                                   input int vbp, input int hp, input int vp);
        exp_t e;
        int ht, vt, h, v;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vbp;
        h  = k % ht;
        v  = (k / ht) % vt;
        e.h  = 16'(h);
        e.v  = 16'(v);
        e.de = (h < ha) && (v < va);
        e.vb = (v >= va);
        e.hs = ((h >= ha + hf) && (h < ha + hf + hsw)) ? (hp != 0) : (hp == 0);
        e.vs = ((v >= va + vf) && (v < va + vf + vsw)) ? (vp != 0) : (vp == 0);
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic exp_t rst_val(input int hp, input int vp);
        exp_t e;
        e    = '0;
        e.hs = (hp == 0);
        e.vs = (vp == 0);
        return e;
    endfunction

    exp_t em_s, em_d;
    int   k_s, k_d;

    // Reference models advance on each sampled pix_en, restart on reset.
    always @(posedge sys_clk) begin
        if (reset_s) begin
            em_s = rst_val(1, 1);
            k_s  = 0;
        end else if (pe_s) begin
            em_s = model(k_s, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1);
            k_s  = (k_s + 1) % 48;
        end else begin
            em_s.ls = 1'b0;
            em_s.fs = 1'b0;
        end
        if (reset_d) begin
            em_d = rst_val(0, 0);
            k_d  = 0;
        end else if (pe_d) begin
            em_d = model(k_d, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
            k_d  = (k_d + 1) % 420000;
        end else begin
            em_d.ls = 1'b0;
            em_d.fs = 1'b0;
        end
    end

    // Every-cycle comparison of both instances against their models.
    always @(negedge sys_clk) begin
        exp_t a;
        a.hs = hs_s; a.vs = vs_s; a.de = de_s; a.vb = vb_s;
        a.h = 16'(hc_s); a.v = 16'(vc_s); a.ls = ls_s; a.fs = fs_s;
        chk("cycle_small", longint'(a), longint'(em_s));
        a.hs = hs_d; a.vs = vs_d; a.de = de_d; a.vb = vb_d;
        a.h = 16'(hc_d); a.v = 16'(vc_d); a.ls = ls_d; a.fs = fs_d;
        chk("cycle_default", longint'(a), longint'(em_d));
    end

    initial begin
        int n, de_n, ls_n, hs_n, vs_n, vb_n, found;
        reset_s = 1'b1; pe_s = 1'b1;
        reset_d = 1'b1; pe_d = 1'b0;

        // Small raster, continuous pix_en.
        repeat (4) @(negedge sys_clk);
        chk("small_reset_outputs", {hs_s, vs_s, de_s, vb_s, ls_s, fs_s, hc_s, vc_s},
            {1'b0, 1'b0, 4'b0, 8'd0});
        reset_s = 1'b0;
        @(negedge sys_clk);
        chk("small_first_pixel", {hc_s, vc_s, de_s, fs_s, ls_s}, {8'd0, 3'b111});

        de_n = 0; ls_n = 0; hs_n = 0; vs_n = 0; vb_n = 0;
        for (n = 1; n <= 500; n++) begin
            de_n += int'(de_s); ls_n += int'(ls_s); hs_n += int'(hs_s);
            vs_n += int'(vs_s); vb_n += int'(vb_s);
            @(negedge sys_clk);
            if (fs_s) break;
        end
        chk("small_frame_period", n, 48);
        chk("small_display_cycles", de_n, 12);
        chk("small_line_starts", ls_n, 6);
        chk("small_hsync_cycles", hs_n, 12);
        chk("small_vsync_cycles", vs_n, 8);
        chk("small_vblank_cycles", vb_n, 24);

        // Half-rate pix_en: frame period doubles.
        for (n = 1; n <= 300; n++) begin
            pe_s = ~pe_s;
            @(negedge sys_clk);
            if (fs_s) break;
        end
        chk("small_halfrate_sync", int'(n <= 300), 1);
        for (n = 1; n <= 300; n++) begin
            pe_s = ~pe_s;
            @(negedge sys_clk);
            if (fs_s) break;
        end
        chk("small_halfrate_period", n, 96);

        // Random enable with occasional mid-frame resets.
        for (int i = 0; i < 3000; i++) begin
            pe_s    = ($urandom_range(0, 3) != 0);
            reset_s = ($urandom_range(0, 199) == 0);
            @(negedge sys_clk);
        end
        reset_s = 1'b0; pe_s = 1'b1;

        // Default 640x480 raster.
        reset_d = 1'b0; pe_d = 1'b1;
        @(negedge sys_clk);
        chk("default_first_pixel", {hc_d, vc_d, de_d, fs_d, ls_d}, {22'd0, 3'b111});
        hs_n = 0;
        for (n = 1; n <= 1000; n++) begin
            hs_n += int'(!hs_d);
            @(negedge sys_clk);
            if (ls_d) break;
        end
        chk("default_line_period", n, 800);
        chk("default_hsync_low_cycles", hs_n, 96);

        found = 0;
        for (n = 0; n < 3000; n++) begin
            if (vc_d == 11'd2 && hc_d == 11'd300) begin
                found = 1;
                break;
            end
            @(negedge sys_clk);
        end
        chk("default_reach_300_2", found, 1);
        reset_d = 1'b1;
        @(negedge sys_clk);
        chk("default_midframe_reset", {hs_d, vs_d, de_d, vb_d, ls_d, fs_d, hc_d, vc_d},
            {1'b1, 1'b1, 4'b0, 22'd0});
        reset_d = 1'b0;
        @(negedge sys_clk);
        chk("default_restart_pixel", {hc_d, vc_d, de_d, fs_d, ls_d, hs_d, vs_d},
            {22'd0, 5'b11111});
        repeat (20) @(negedge sys_clk);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
